// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus arbiter: FSM states, transaction owner, access sizes.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter_starve_ctr.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module arb_starve_ctr #(
    parameter int LIM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_lim
);

    localparam int W = $clog2(LIM + 1);
    localparam logic [W-1:0] LIM_C = W'(LIM);
    localparam logic [W-1:0] ONE_C = W'(1);

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_nxt_s;

    // Next count: clear wins over increment, increment stops at the limit.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = {W{1'b0}};
        end else if (inc && (cnt_r != LIM_C)) begin
            cnt_nxt_s = cnt_r + ONE_C;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register with the limit flag registered alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= {W{1'b0}};
            at_lim <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            at_lim <= (cnt_nxt_s == LIM_C);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and data access,
// one transaction at a time, data first with a fetch starvation guard.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_cancel,
    output logic          i_addr_ok,
    output logic          i_data_ok,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_addr_ok,
    output logic          d_data_ok,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_wr,
    output logic [1:0]    m_size,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_addr_ok,
    input  logic          m_data_ok,
    input  logic [DW-1:0] m_rdata
);

    state_t state_r;
    owner_t owner_r;
    logic   drop_r;
    logic   starve_at_lim_s;
    logic   grant_d_s;
    logic   grant_i_s;
    logic   resp_s;

    arb_starve_ctr #(.LIM(STARVE_LIM)) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (grant_d_s & i_req),
        .clr    (grant_i_s | (grant_d_s & ~i_req)),
        .at_lim (starve_at_lim_s)
    );

    // Grant decision in IDLE and bus completion detection in ADDR/DATA.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        resp_s    = 1'b0;
        if ((state_r == IDLE) && !rst) begin
            grant_d_s = d_req && !(i_req && starve_at_lim_s);
            grant_i_s = i_req && !grant_d_s;
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
        case (state_r)
            ADDR:    resp_s = m_addr_ok && m_data_ok;
            DATA:    resp_s = m_data_ok;
            default: resp_s = 1'b0;
        endcase
    end

    assign i_addr_ok = grant_i_s;
    assign d_addr_ok = grant_d_s;
    // A cancel arriving in the completion cycle itself must also swallow the response.
    assign i_data_ok = resp_s && (owner_r == OWN_I) && !drop_r && !i_cancel;
    assign d_data_ok = resp_s && (owner_r == OWN_D);
    assign i_rdata   = i_data_ok ? m_rdata : {DW{1'b0}};
    assign d_rdata   = d_data_ok ? m_rdata : {DW{1'b0}};

    // Transaction FSM with the latched bus request fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            owner_r <= OWN_NONE;
            drop_r  <= 1'b0;
            m_req   <= 1'b0;
            m_wr    <= 1'b0;
            m_size  <= 2'd0;
            m_addr  <= {AW{1'b0}};
            m_wdata <= {DW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_d_s) begin
                        state_r <= ADDR;
                        owner_r <= OWN_D;
                        drop_r  <= 1'b0;
                        m_req   <= 1'b1;
                        m_wr    <= d_wr;
                        m_size  <= d_size;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                    end else if (grant_i_s) begin
                        state_r <= ADDR;
                        owner_r <= OWN_I;
                        drop_r  <= i_cancel;
                        m_req   <= 1'b1;
                        m_wr    <= 1'b0;
                        m_size  <= SZ_WORD;
                        m_addr  <= i_addr;
                        m_wdata <= {DW{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ADDR: begin
                    if ((owner_r == OWN_I) && i_cancel) begin
                        drop_r <= 1'b1;
                    end else begin
                        drop_r <= drop_r;
                    end
                    if (m_addr_ok && m_data_ok) begin
                        state_r <= IDLE;
                        owner_r <= OWN_NONE;
                        drop_r  <= 1'b0;
                        m_req   <= 1'b0;
                    end else if (m_addr_ok) begin
                        state_r <= DATA;
                        m_req   <= 1'b0;
                    end else begin
                        state_r <= ADDR;
                    end
                end
                DATA: begin
                    if ((owner_r == OWN_I) && i_cancel) begin
                        drop_r <= 1'b1;
                    end else begin
                        drop_r <= drop_r;
                    end
                    if (m_data_ok) begin
                        state_r <= IDLE;
                        owner_r <= OWN_NONE;
                        drop_r  <= 1'b0;
                    end else begin
                        state_r <= DATA;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    owner_r <= OWN_NONE;
                    drop_r  <= 1'b0;
                    m_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule
